// File: rtl/vnu_layer.sv
// Layered-decoding variable-node update: q = L - r_old toward the CNU, L_new = q + r_new back to posterior memory.
// Latency CNU_LAT+2 en-cycles from i_in_valid to o_out_valid; one row per en-cycle, bubbles carried through.
// No backpressure: i_en low freezes every register together with the CNU.
module vnu_layer #(
  parameter int D       = 8,
  parameter int RES_W   = 8,
  parameter int EXT_W   = 3,
  parameter int CNU_LAT = 2,
  parameter int ROWS    = 16,
  localparam int DATA_W = RES_W + EXT_W,
  localparam int CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_in_valid,
  input  logic [D*DATA_W-1:0]   i_l_in,
  input  logic [D*RES_W-1:0]    i_r_old,
  output logic [D*DATA_W-1:0]   o_q_out,
  output logic                  o_q_valid,
  input  logic [D*RES_W-1:0]    i_r_new,
  output logic [D*DATA_W-1:0]   o_l_out,
  output logic                  o_out_valid,
  output logic [CNT_W-1:0]      o_row_idx,
  output logic                  o_layer_done
);

  // Symmetric clamp: the most-negative code is never produced, so the CNU can take abs() safely.
  localparam logic signed [DATA_W:0] SAT_HI   = (DATA_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [DATA_W:0] SAT_LO   = -SAT_HI;
  localparam logic [CNT_W-1:0]       LAST_ROW = CNT_W'(ROWS - 1);

  function automatic logic signed [DATA_W:0] sext_l(input logic [DATA_W-1:0] x);
    return {x[DATA_W-1], x};
  endfunction

  function automatic logic signed [DATA_W:0] sext_r(input logic [RES_W-1:0] x);
    return {{(EXT_W+1){x[RES_W-1]}}, x};
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [DATA_W:0] x);
    logic signed [DATA_W:0] y;
    if (x > SAT_HI)      y = SAT_HI;
    else if (x < SAT_LO) y = SAT_LO;
    else                 y = x;
    return y[DATA_W-1:0];
  endfunction

  logic [D*DATA_W-1:0] r_q;
  logic                r_q_vld;
  logic [D*DATA_W-1:0] r_dl_dat [CNU_LAT];
  logic [CNU_LAT-1:0]  r_dl_vld;
  logic [D*DATA_W-1:0] r_l;
  logic                r_out_vld;
  logic [CNT_W-1:0]    r_row;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ld;

  logic [D*DATA_W-1:0] w_q_nxt;
  logic [D*DATA_W-1:0] w_l_nxt;
  logic [D*DATA_W-1:0] w_tail_dat;
  logic                w_tail_vld;
  logic [CNT_W-1:0]    w_cnt_nxt;

  assign w_tail_dat = r_dl_dat[CNU_LAT-1];
  assign w_tail_vld = r_dl_vld[CNU_LAT-1];
  assign w_cnt_nxt  = (r_cnt == LAST_ROW) ? '0 : r_cnt + CNT_W'(1);

  always_comb begin
    w_q_nxt = '0;
    w_l_nxt = '0;
    for (int i = 0; i < D; i++) begin
      w_q_nxt[i*DATA_W +: DATA_W] = sat(sext_l(i_l_in[i*DATA_W +: DATA_W])
                                        - sext_r(i_r_old[i*RES_W +: RES_W]));
      w_l_nxt[i*DATA_W +: DATA_W] = sat(sext_l(w_tail_dat[i*DATA_W +: DATA_W])
                                        + sext_r(i_r_new[i*RES_W +: RES_W]));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q       <= '0;
      r_q_vld   <= 1'b0;
      for (int k = 0; k < CNU_LAT; k++) r_dl_dat[k] <= '0;
      r_dl_vld  <= '0;
      r_l       <= '0;
      r_out_vld <= 1'b0;
      r_row     <= '0;
      r_cnt     <= '0;
      r_ld      <= 1'b0;
    end else if (i_en) begin
      r_q         <= w_q_nxt;
      r_q_vld     <= i_in_valid;
      // The delay line keeps each row's q aligned with the CNU's r_new for that row.
      r_dl_dat[0] <= r_q;
      r_dl_vld[0] <= r_q_vld;
      for (int k = 1; k < CNU_LAT; k++) begin
        r_dl_dat[k] <= r_dl_dat[k-1];
        r_dl_vld[k] <= r_dl_vld[k-1];
      end
      r_out_vld <= w_tail_vld;
      r_ld      <= w_tail_vld && (r_cnt == LAST_ROW);
      if (w_tail_vld) begin
        r_l   <= w_l_nxt;
        r_row <= r_cnt;
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  assign o_q_out      = r_q;
  assign o_q_valid    = r_q_vld;
  assign o_l_out      = r_l;
  assign o_out_valid  = r_out_vld;
  assign o_row_idx    = r_row;
  assign o_layer_done = r_ld;

endmodule

// File: tb/tb_vnu_layer.sv
// Randomized bench for vnu_layer with a row-level reference model and a CNU stand-in driving r_new.
module tb_vnu_layer;
  localparam int D     = 8;
  localparam int RES_W = 8;
  localparam int EXT_W = 3;
  localparam int DW    = RES_W + EXT_W;
  localparam int LAT   = 2;
  localparam int ROWS  = 16;
  localparam int CW    = 4;
  localparam int LIM   = 1023;
  localparam int MAXR  = 256;
  localparam int MAXE  = 1024;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               in_vld = 1'b0;
  logic [D*DW-1:0]    l_in = '0;
  logic [D*RES_W-1:0] r_old = '0;
  logic [D*RES_W-1:0] r_new = '0;
  logic [D*DW-1:0]    q_out;
  logic [D*DW-1:0]    l_out;
  logic               q_vld;
  logic               out_vld;
  logic               layer_done;
  logic [CW-1:0]      row_idx;

  vnu_layer #(.D(D), .RES_W(RES_W), .EXT_W(EXT_W), .CNU_LAT(LAT), .ROWS(ROWS)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_in_valid(in_vld),
    .i_l_in(l_in), .i_r_old(r_old), .o_q_out(q_out), .o_q_valid(q_vld),
    .i_r_new(r_new), .o_l_out(l_out), .o_out_valid(out_vld),
    .o_row_idx(row_idx), .o_layer_done(layer_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Row table: each row's L, r_old and the r_new the CNU will return for it.
  int row_l[MAXR][D];
  int row_ro[MAXR][D];
  int row_rn[MAXR][D];
  int nrows = 0;
  int issue[MAXE];          // row id sampled at each en-cycle, -1 for a bubble
  int ecnt = 0;
  int cur_l[D], cur_ro[D], cur_rn[D];
  int eq[D], el[D];
  int eqv = 0, eov = 0, erow = 0, eld = 0, ecntr = 0;
  int obs_outs = 0, nld = 0;
  int ld_pos[8];

  task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    if (x > LIM) return LIM;
    if (x < -LIM) return -LIM;
    return x;
  endfunction

  function automatic int rnd_l();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  function automatic int rnd_r();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic int new_row(input int l, input int ro, input int rn);
    for (int i = 0; i < D; i++) begin
      row_l[nrows][i] = l; row_ro[nrows][i] = ro; row_rn[nrows][i] = rn;
    end
    nrows++;
    return nrows - 1;
  endfunction

  function automatic int new_rand_row();
    for (int i = 0; i < D; i++) begin
      row_l[nrows][i] = rnd_l(); row_ro[nrows][i] = rnd_r(); row_rn[nrows][i] = rnd_r();
    end
    nrows++;
    return nrows - 1;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < D; i++) begin
      l_in[i*DW +: DW]        = DW'(cur_l[i]);
      r_old[i*RES_W +: RES_W] = RES_W'(cur_ro[i]);
      r_new[i*RES_W +: RES_W] = RES_W'(cur_rn[i]);
    end
  endtask

  task automatic check_all();
    check("q_valid", q_vld, eqv);
    check("out_valid", out_vld, eov);
    check("layer_done", layer_done, eld);
    if (eov != 0) check("row_idx", row_idx, erow);
    for (int i = 0; i < D; i++) begin
      check($sformatf("q_out[%0d]", i), $signed(q_out[i*DW +: DW]), eq[i]);
      check($sformatf("l_out[%0d]", i), $signed(l_out[i*DW +: DW]), el[i]);
    end
  endtask

  // One clock: e = en, v = in_valid, id = row to present when v.
  task automatic step(input bit e, input bit v, input int id);
    int tr;
    tr = (ecnt >= LAT + 1) ? issue[ecnt-LAT-1] : -1;
    for (int i = 0; i < D; i++) begin
      cur_l[i]  = (e && v) ? row_l[id][i]  : rnd_l();
      cur_ro[i] = (e && v) ? row_ro[id][i] : rnd_r();
      cur_rn[i] = (e && tr >= 0) ? row_rn[tr][i] : rnd_r();
    end
    en = e; in_vld = v;
    drive_bus();
    @(posedge clk); #1;
    if (e) begin
      issue[ecnt] = v ? id : -1;
      eqv = v;
      for (int i = 0; i < D; i++) eq[i] = sat(cur_l[i] - cur_ro[i]);
      if (tr >= 0) begin
        for (int i = 0; i < D; i++)
          el[i] = sat(sat(row_l[tr][i] - row_ro[tr][i]) + row_rn[tr][i]);
        eov = 1; erow = ecntr; eld = (ecntr == ROWS - 1) ? 1 : 0;
        ecntr = (ecntr + 1) % ROWS;
      end else begin
        eov = 0; eld = 0;
      end
      ecnt++;
    end
    check_all();
    if (e && out_vld === 1'b1) begin
      obs_outs++;
      if (layer_done === 1'b1 && nld < 8) begin
        ld_pos[nld] = obs_outs;
        nld++;
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < D; i++) begin
      cur_l[i] = rnd_l(); cur_ro[i] = rnd_r(); cur_rn[i] = rnd_r();
    end
    rst = 1'b1; en = 1'($urandom_range(0, 1)); in_vld = 1'b1;
    drive_bus();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < D; i++) begin eq[i] = 0; el[i] = 0; end
    eqv = 0; eov = 0; erow = 0; eld = 0; ecntr = 0;
    for (int k = 0; k < ecnt; k++) issue[k] = -1;
    obs_outs = 0; nld = 0;
    check_all();
  endtask

  initial begin
    int id, a, b, sent, base;
    for (int k = 0; k < MAXE; k++) issue[k] = -1;

    // Reset with stale inputs, then idle: nothing may come out.
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 0);

    // Basic single row.
    id = new_row(100, -20, 30);
    step(1'b1, 1'b1, id);
    check("basic_q", $signed(q_out[0 +: DW]), 120);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 0);
    check("basic_vld", out_vld, 1);
    check("basic_l", $signed(l_out[3*DW +: DW]), 150);

    // Saturation in both directions.
    a = new_row(1000, -50, 10);
    b = new_row(-1000, 100, -128);
    step(1'b1, 1'b1, a);
    check("sat_q_hi", $signed(q_out[5*DW +: DW]), 1023);
    step(1'b1, 1'b1, b);
    check("sat_q_lo", $signed(q_out[2*DW +: DW]), -1023);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    check("sat_l_hi", $signed(l_out[7*DW +: DW]), 1023);
    step(1'b1, 1'b0, 0);
    check("sat_l_lo", $signed(l_out[1*DW +: DW]), -1023);

    // Streaming with en dropped every third cycle.
    base = obs_outs;
    sent = 0;
    for (int c = 0; sent < 20 && c < 100; c++) begin
      if ((c % 3) != 2) begin
        step(1'b1, 1'b1, new_rand_row());
        sent++;
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 0);
      end
    end
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 0);
    check("stream_count", obs_outs - base, 20);

    // Random en / in_valid mix.
    for (int c = 0; c < 80; c++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), 0);
      else if ($urandom_range(0, 9) < 6) step(1'b1, 1'b1, new_rand_row());
      else step(1'b1, 1'b0, 0);
    end

    // Layer wrap: 33 rows from a fresh counter.
    do_reset();
    for (int c = 0; c < 33; c++) step(1'b1, 1'b1, new_rand_row());
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 0);
    check("wrap_outs", obs_outs, 33);
    check("wrap_nld", nld, 2);
    check("wrap_ld0", ld_pos[0], 16);
    check("wrap_ld1", ld_pos[1], 32);

    // Reset with three rows in flight.
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, new_rand_row());
    do_reset();
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 0);
    check("midrst_none", obs_outs, 0);
    step(1'b1, 1'b1, new_rand_row());
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 0);
    check("midrst_vld", out_vld, 1);
    check("midrst_row0", row_idx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
